// File: rtl/cmp_seq_param.sv
// cmp_seq_param: digit-serial MSB-first magnitude comparator, signed or unsigned,
// with early termination at the first differing DIGIT-wide slice. Rev 1.0
`default_nettype none

module cmp_seq_param #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             a_is_equal,
   output logic             a_is_greater,
   output logic             a_is_smaller
);

   localparam int N  = WIDTH / DIGIT;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
   localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

   if (WIDTH <= 0 || DIGIT <= 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("cmp_seq_param: WIDTH must be a positive multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             sm_q;
   logic [IW-1:0]    idx_q;
   logic             busy_q, done_q, eq_q, gt_q, lt_q;

   logic [DIGIT-1:0] flip_d, dig_a_d, dig_b_d;

   // Operands shift left each SCAN cycle, so the digit under test is always the top slice.
   assign flip_d  = (sm_q && idx_q == '0) ? MSB_MASK : '0;
   assign dig_a_d = a_q[WIDTH-1 -: DIGIT] ^ flip_d;
   assign dig_b_d = b_q[WIDTH-1 -: DIGIT] ^ flip_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  sm_q    <= signed_mode;
                  idx_q   <= '0;
                  eq_q    <= 1'b0;
                  gt_q    <= 1'b0;
                  lt_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (dig_a_d != dig_b_d) begin
                  gt_q    <= (dig_a_d > dig_b_d);
                  lt_q    <= (dig_a_d < dig_b_d);
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (idx_q == LAST_IDX) begin
                  eq_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IW'(1);
                  a_q   <= a_q << DIGIT;
                  b_q   <= b_q << DIGIT;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign a_is_equal   = eq_q;
   assign a_is_greater = gt_q;
   assign a_is_smaller = lt_q;

endmodule

`default_nettype wire

// File: tb/tb_cmp_seq_param.sv
// tb_cmp_seq_param: directed vector table and corner sequences on a (16,4) instance,
// plus scoreboarded random compares on (16,4), (32,8), (8,8) and (12,1) instances.
`default_nettype none

module tb_cmp_seq_param;

   localparam int NRND = 2500;

   typedef struct {
      logic [2:0] res;   // {equal, greater, smaller}
      int         lat;
   } exp_t;

   typedef struct {
      logic        sm;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  res;
      int          lat;
   } tv_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, signed_mode;
   logic [15:0] a, b;
   logic        busy, done, eq, gt, lt;
   logic        rnd_go = 1'b0;
   logic [3:0]  x_done = '0;

   int n_cmp  = 0;
   int n_fail = 0;

   exp_t sb[$];

   always #5 clk = ~clk;

   cmp_seq_param #(.WIDTH(16), .DIGIT(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy), .done(done),
      .a_is_equal(eq), .a_is_greater(gt), .a_is_smaller(lt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
      end
   endtask

   // Reference: full-width numeric compare plus first-differing-digit search.
   function automatic void ref_cmp(input logic [63:0] ra, input logic [63:0] rb, input int w,
                                   input int d, input logic sm, output logic [2:0] res, output int k);
      logic signed [64:0] xa, xb;
      logic [63:0] msk, dm, da, db;
      logic found;
      int nd;
      msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      dm  = (64'd1 << d) - 64'd1;
      xa  = {1'b0, ra & msk};
      xb  = {1'b0, rb & msk};
      if (sm && ra[w-1]) xa = xa | ~{1'b0, msk};
      if (sm && rb[w-1]) xb = xb | ~{1'b0, msk};
      res   = (xa == xb) ? 3'b100 : ((xa > xb) ? 3'b010 : 3'b001);
      nd    = w / d;
      k     = nd - 1;
      found = 1'b0;
      for (int i = 0; i < nd; i++) begin
         da = (ra >> (w - (i + 1) * d)) & dm;
         db = (rb >> (w - (i + 1) * d)) & dm;
         if (!found && da != db) begin
            k     = i;
            found = 1'b1;
         end
      end
   endfunction

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_main(input tv_t v, input int idx);
      exp_t e;
      int   n;
      sb.push_back('{res: v.res, lat: v.lat});
      signed_mode = v.sm; a = v.a; b = v.b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("vec%0d busy_after_start", idx), busy, 1);
      wait_done(n);
      e = sb.pop_front();
      if (!done) begin
         chk($sformatf("vec%0d done_timeout", idx), 0, 1);
         return;
      end
      chk($sformatf("vec%0d result", idx), {eq, gt, lt}, e.res);
      chk($sformatf("vec%0d latency", idx), n, e.lat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d busy_done_after", idx), {busy, done}, 2'b00);
      chk($sformatf("vec%0d result_hold", idx), {eq, gt, lt}, e.res);
   endtask

   tv_t tv[12];

   initial begin
      int   n;
      logic seen;

      tv[0]  = '{0, 16'h1234, 16'h1234, 3'b100, 4};
      tv[1]  = '{0, 16'h8000, 16'h7FFF, 3'b010, 1};
      tv[2]  = '{1, 16'h8000, 16'h7FFF, 3'b001, 1};
      tv[3]  = '{0, 16'h12F0, 16'h1200, 3'b010, 3};
      tv[4]  = '{1, 16'hFFFE, 16'hFFFF, 3'b001, 4};
      tv[5]  = '{1, 16'h0000, 16'hFFFF, 3'b010, 1};
      tv[6]  = '{0, 16'h0000, 16'hFFFF, 3'b001, 1};
      tv[7]  = '{1, 16'h7FFF, 16'h8000, 3'b010, 1};
      tv[8]  = '{0, 16'h1235, 16'h1234, 3'b010, 4};
      tv[9]  = '{1, 16'h8000, 16'h8000, 3'b100, 4};
      tv[10] = '{1, 16'hFF00, 16'hF000, 3'b010, 2};
      tv[11] = '{0, 16'h0000, 16'h0000, 3'b100, 4};

      rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, done, eq, gt, lt}, 5'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) run_main(tv[i], i);

      // Start while busy is ignored, including its new operands.
      a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n);
      chk("busy_start_latency", n + 1, 4);
      chk("busy_start_result", {eq, gt, lt}, 3'b001);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("busy_start_no_second_done", seen, 1'b0);

      // Asynchronous reset mid-SCAN aborts with no done.
      a = 16'h1230; b = 16'h1231; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", {busy, done, eq, gt, lt}, 5'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("abort_no_done", seen, 1'b0);
      run_main('{0, 16'h0005, 16'h0003, 3'b010, 4}, 100);

      // Start held high: back-to-back compares.
      a = 16'h0003; b = 16'h0003; signed_mode = 1'b0; start = 1'b1;
      wait_done(n);
      chk("b2b_first_latency", n, 5);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done && n < 40);
      chk("b2b_gap", n, 6);
      chk("b2b_result", {eq, gt, lt}, 3'b100);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      rnd_go = 1'b1;
      wait (&x_done);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   for (genvar g = 0; g < 4; g++) begin : g_rnd
      localparam int W = (g == 0) ? 16 : (g == 1) ? 32 : (g == 2) ? 8 : 12;
      localparam int D = (g == 0) ? 4  : (g == 1) ? 8  : (g == 2) ? 8 : 1;

      logic         st, sm;
      logic [W-1:0] va, vb;
      logic         bz, dn, xeq, xgt, xlt;
      exp_t         q[$];

      cmp_seq_param #(.WIDTH(W), .DIGIT(D)) u_dut (
         .clk(clk), .rst(rst), .start(st), .signed_mode(sm),
         .a(va), .b(vb), .busy(bz), .done(dn),
         .a_is_equal(xeq), .a_is_greater(xgt), .a_is_smaller(xlt)
      );

      initial begin
         logic [63:0] ra, rb;
         logic [2:0]  r;
         exp_t        e;
         int          k, n;
         st = 1'b0; sm = 1'b0; va = '0; vb = '0;
         wait (rnd_go);
         @(posedge clk); #1;
         for (int i = 0; i < NRND; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
               0: rb = ra;
               1: rb = ra ^ (64'd1 << $urandom_range(0, W - 1));
               default: ;
            endcase
            va = W'(ra); vb = W'(rb); sm = 1'($urandom_range(0, 1));
            ref_cmp(64'(va), 64'(vb), W, D, sm, r, k);
            q.push_back('{res: r, lat: k + 1});
            st = 1'b1;
            @(posedge clk); #1;
            st = 1'b0;
            n = 0;
            while (!dn && n < W + 8) begin
               @(posedge clk); #1;
               n++;
            end
            e = q.pop_front();
            if (!dn) begin
               chk($sformatf("rnd(%0d,%0d) #%0d done_timeout", W, D, i), 0, 1);
            end else if ({xeq, xgt, xlt} !== e.res || n !== e.lat) begin
               chk($sformatf("rnd(%0d,%0d) #%0d sm=%0d a=%0h b=%0h res/lat", W, D, i, sm, va, vb),
                   {32'(n), 29'd0, xeq, xgt, xlt}, {32'(e.lat), 29'd0, e.res});
            end else begin
               n_cmp++;
            end
            @(posedge clk); #1;
         end
         x_done[g] = 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/cmp_seq_param.md
CMP_SEQ_PARAM -- requirements
Module: cmp_seq_param

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a positive multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4, bits compared per clock cycle.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be exactly as listed, clock and reset first:
  clk  input  1  rising-edge clock.
  rst  input  1  asynchronous active-high reset.
  start  input  1  request a compare; sampled only in IDLE.
  signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start.
  a  input  WIDTH  operand A; latched with start.
  b  input  WIDTH  operand B; latched with start.
  busy  output  1  high in SCAN and DONE.
  done  output  1  one-cycle pulse; results valid.
  a_is_equal  output  1  registered result, A == B.
  a_is_greater  output  1  registered result, A > B.
  a_is_smaller  output  1  registered result, A < B.

Function
REQ-005 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-006 IDLE: on a clk edge with start=1, the block SHALL latch a, b and signed_mode, set the digit index to 0 (the MSB digit), clear all three result outputs and enter SCAN.
REQ-007 In IDLE with start=0, the block SHALL hold its state and outputs.
REQ-008 SCAN: each cycle SHALL compare one DIGIT-wide slice of the latched operands, MSB-first, where digit k = bits [WIDTH-1-k*DIGIT -: DIGIT].
REQ-009 Signed mode: in digit 0 only, the operand MSBs SHALL be inverted before the compare; all other digits SHALL compare unsigned.
REQ-010 Early termination: at the first digit that differs, the block SHALL register greater or smaller per that digit and enter DONE at the same edge.
REQ-011 If all N = WIDTH/DIGIT digits are equal, the block SHALL register a_is_equal=1 at the edge that evaluates digit N-1 and enter DONE.
REQ-012 Latency: with start accepted at edge E0 and first differing digit k (or k = N-1 if A == B), the results SHALL be registered at edge E0+k+1.
REQ-013 done SHALL be high for exactly the cycle following E0+k+1.
REQ-014 DONE: the block SHALL return to IDLE at the next edge, unconditionally.
REQ-015 start while busy=1 SHALL be ignored, and operand or mode changes while busy SHALL have no effect.
REQ-016 Once done has pulsed, exactly one of a_is_equal, a_is_greater, a_is_smaller SHALL be high, and it SHALL hold until the next start is accepted.
REQ-017 A start held continuously high SHALL produce back-to-back compares, each beginning on the first IDLE edge.
REQ-018 For WIDTH == DIGIT (N = 1), every compare SHALL complete in one SCAN cycle.

Reset
REQ-019 rst=1 SHALL immediately force: state IDLE, busy=0, done=0, all three results 0, latched operands and digit index 0.
REQ-020 Reset asserted mid-SCAN or in DONE SHALL abort the compare; no done pulse SHALL be produced for the aborted operation.
REQ-021 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=16, DIGIT=4, start at edge E0)
REQ-022 a=0x1234, b=0x1234, unsigned -> a_is_equal=1 at E0+4; done high one cycle; busy high for 5 cycles.
REQ-023 a=0x8000, b=0x7FFF: unsigned -> a_is_greater=1 at E0+1; signed -> a_is_smaller=1 at E0+1.
REQ-024 a=0x12F0, b=0x1200, unsigned -> a_is_greater=1 at E0+3; signed a=0xFFFE, b=0xFFFF -> a_is_smaller=1 at E0+4.
REQ-025 Start a=0x0001, b=0x0002, then pulse start with a=0xFFFF, b=0x0000 at E0+1 -> second start ignored; a_is_smaller=1 at E0+4.
REQ-026 Start a=0x1230, b=0x1231; assert rst at E0+2 -> outputs 0, no done; next start a=5, b=3 -> a_is_greater=1 at its E0+4.
REQ-027 Random regression of 10^4 operand pairs in both modes, checked against a reference model, for parameter sets (16,4), (32,8), (8,8) and (12,1).
